// File: rtl/hidden_layer_sequencer.sv
// Sequences one fully-connected hidden layer: for each unit, streams activations and weights,
// accumulates their products, then writes the shifted and clamped result to the hidden RAM.
module hidden_layer_sequencer #(
   parameter int unsigned N_INPUTS   = 784,
   parameter int unsigned N_HIDDEN   = 32,
   parameter int unsigned FRAC_SHIFT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [9:0]  in_addr,
   input  logic [7:0]  in_data,
   output logic [14:0] wt_addr,
   input  logic [7:0]  wt_data,
   output logic [4:0]  hid_addr,
   output logic [7:0]  hid_data,
   output logic        hid_we,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {StIdle, StRun, StDrain, StWrite, StDone} state_e;

   localparam logic [9:0] LastIn  = 10'(N_INPUTS - 1);
   localparam logic [4:0] LastHid = 5'(N_HIDDEN - 1);

   state_e             state_q, state_d;
   logic [9:0]         i_idx_q, i_idx_d;
   logic [14:0]        wt_addr_q, wt_addr_d;
   logic [4:0]         h_idx_q, h_idx_d;
   logic signed [25:0] acc_q, acc_d;
   logic               valid_q, valid_d;
   logic               hid_we_q, hid_we_d;
   logic [4:0]         hid_addr_q, hid_addr_d;
   logic [7:0]         hid_data_q, hid_data_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic signed [16:0] prod;
   logic signed [25:0] acc_sum;
   logic signed [25:0] acc_sh;
   logic [7:0]         acc_sat;

   // Activation is unsigned, so it is zero-extended before the signed multiply.
   assign prod    = $signed({1'b0, in_data}) * $signed(wt_data);
   assign acc_sum = acc_q + {{9{prod[16]}}, prod};
   assign acc_sh  = acc_sum >>> FRAC_SHIFT;

   always_comb begin
      acc_sat = acc_sh[7:0];
      if (acc_sh[25]) begin
         acc_sat = 8'd0;
      end else if (|acc_sh[24:8]) begin
         acc_sat = 8'd255;
      end
   end

   always_comb begin
      state_d    = state_q;
      i_idx_d    = i_idx_q;
      wt_addr_d  = wt_addr_q;
      h_idx_d    = h_idx_q;
      acc_d      = valid_q ? acc_sum : acc_q;
      valid_d    = (state_q == StRun);
      hid_we_d   = 1'b0;
      hid_addr_d = hid_addr_q;
      hid_data_d = hid_data_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRun;
               i_idx_d   = '0;
               wt_addr_d = '0;
               h_idx_d   = '0;
               acc_d     = '0;
            end
         end
         StRun: begin
            if (i_idx_q == LastIn) begin
               state_d = StDrain;
            end else begin
               i_idx_d   = i_idx_q + 10'd1;
               wt_addr_d = wt_addr_q + 15'd1;
            end
         end
         StDrain: begin
            // The last product lands this cycle, so the write data comes from the summed value.
            state_d    = StWrite;
            hid_we_d   = 1'b1;
            hid_addr_d = h_idx_q;
            hid_data_d = acc_sat;
         end
         StWrite: begin
            if (h_idx_q == LastHid) begin
               state_d = StDone;
            end else begin
               state_d   = StRun;
               h_idx_d   = h_idx_q + 5'd1;
               i_idx_d   = '0;
               wt_addr_d = wt_addr_q + 15'd1;
               acc_d     = '0;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         i_idx_q    <= '0;
         wt_addr_q  <= '0;
         h_idx_q    <= '0;
         acc_q      <= '0;
         valid_q    <= 1'b0;
         hid_we_q   <= 1'b0;
         hid_addr_q <= '0;
         hid_data_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_idx_q    <= i_idx_d;
         wt_addr_q  <= wt_addr_d;
         h_idx_q    <= h_idx_d;
         acc_q      <= acc_d;
         valid_q    <= valid_d;
         hid_we_q   <= hid_we_d;
         hid_addr_q <= hid_addr_d;
         hid_data_q <= hid_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign in_addr  = i_idx_q;
   assign wt_addr  = wt_addr_q;
   assign hid_addr = hid_addr_q;
   assign hid_data = hid_data_q;
   assign hid_we   = hid_we_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
